// File: rtl/matmul_engine_param.sv
// Runtime-sized matrix multiplier C = A x B (M x K times K x N, each up to MAX_DIM),
// computing LANES rows of C per MAC cycle. Define MATMUL_SAT_EN for saturating accumulation.
module matmul_engine_param #(
  parameter int DATA_W  = 16,
  parameter int MAX_DIM = 4,
  parameter int LANES   = 2,
  parameter int ACC_W   = 2*DATA_W + $clog2(MAX_DIM)
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                start,
  input  logic                                signed_mode,
  input  logic [$clog2(MAX_DIM+1)-1:0]        m_i,
  input  logic [$clog2(MAX_DIM+1)-1:0]        k_i,
  input  logic [$clog2(MAX_DIM+1)-1:0]        n_i,
  input  logic [DATA_W*MAX_DIM*MAX_DIM-1:0]   a_i,
  input  logic [DATA_W*MAX_DIM*MAX_DIM-1:0]   b_i,
  output logic [ACC_W*MAX_DIM*MAX_DIM-1:0]    c_o,
  output logic                                busy,
  output logic                                done,
  output logic                                err,
  output logic                                ovf
);

  localparam int DIM_W  = $clog2(MAX_DIM+1);
  localparam int SEL_W  = (MAX_DIM > 1) ? $clog2(MAX_DIM) : 1;
  localparam int IDX_W  = $clog2(2*MAX_DIM+1);
  localparam int PROD_W = 2*DATA_W;

  typedef enum logic [1:0] {IDLE, CLEAR, MAC, DONE} state_t;
  state_t state, state_next;

  logic [DATA_W-1:0] a_q   [MAX_DIM][MAX_DIM];
  logic [DATA_W-1:0] b_q   [MAX_DIM][MAX_DIM];
  logic [ACC_W-1:0]  c_mem [MAX_DIM][MAX_DIM];
  logic [DIM_W-1:0]  m_q, k_q, n_q;
  logic              signed_q;
  logic [IDX_W-1:0]  i_idx;
  logic [SEL_W-1:0]  j_idx, p_idx;
  logic              err_q;

  logic              dims_bad, p_last, j_last, rows_done, mac_last;
  logic [IDX_W-1:0]  i_step;

  logic [IDX_W-1:0]  row_full [LANES];
  logic              lane_en  [LANES];
  logic [SEL_W-1:0]  row_sel  [LANES];
  logic [PROD_W-1:0] ext_a    [LANES];
  logic [PROD_W-1:0] ext_b    [LANES];
  logic [PROD_W-1:0] prod     [LANES];
  logic [ACC_W-1:0]  prod_ext [LANES];
  logic [ACC_W-1:0]  c_old    [LANES];
  logic [ACC_W-1:0]  acc_new  [LANES];
`ifdef MATMUL_SAT_EN
  logic [ACC_W:0]    sum      [LANES];
  logic              lane_sat [LANES];
  logic              ovf_q;
`endif

  assign dims_bad = (m_i == '0) || (m_i > DIM_W'(MAX_DIM)) ||
                    (k_i == '0) || (k_i > DIM_W'(MAX_DIM)) ||
                    (n_i == '0) || (n_i > DIM_W'(MAX_DIM));

  assign p_last    = (DIM_W'(p_idx) + DIM_W'(1)) == k_q;
  assign j_last    = (DIM_W'(j_idx) + DIM_W'(1)) == n_q;
  assign i_step    = i_idx + IDX_W'(LANES);
  assign rows_done = i_step >= IDX_W'(m_q);
  assign mac_last  = p_last && j_last && rows_done;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          if (dims_bad) state_next = DONE;
          else          state_next = CLEAR;
        end
      end
      CLEAR:   state_next = MAC;
      MAC:     if (mac_last) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == CLEAR) || (state == MAC);
    done = (state == DONE);
  end

  // Operands, dimensions and mode are captured only when a request is accepted.
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      m_q      <= m_i;
      k_q      <= k_i;
      n_q      <= n_i;
      signed_q <= signed_mode;
      for (int r = 0; r < MAX_DIM; r++) begin
        for (int c = 0; c < MAX_DIM; c++) begin
          a_q[r][c] <= a_i[(r*MAX_DIM+c)*DATA_W +: DATA_W];
          b_q[r][c] <= b_i[(r*MAX_DIM+c)*DATA_W +: DATA_W];
        end
      end
    end
  end

  // Masked lanes point at row 0 so the operand muxes never index past the array.
  always_comb begin
    for (int g = 0; g < LANES; g++) begin
      row_full[g] = i_idx + IDX_W'(g);
      lane_en[g]  = (state == MAC) && (row_full[g] < IDX_W'(m_q));
      row_sel[g]  = lane_en[g] ? row_full[g][SEL_W-1:0] : '0;
      ext_a[g]    = signed_q ? PROD_W'($signed(a_q[row_sel[g]][p_idx])) : PROD_W'(a_q[row_sel[g]][p_idx]);
      ext_b[g]    = signed_q ? PROD_W'($signed(b_q[p_idx][j_idx])) : PROD_W'(b_q[p_idx][j_idx]);
      prod[g]     = ext_a[g] * ext_b[g];
      prod_ext[g] = signed_q ? ACC_W'($signed(prod[g])) : ACC_W'(prod[g]);
      c_old[g]    = c_mem[row_sel[g]][j_idx];
`ifdef MATMUL_SAT_EN
      sum[g] = {1'b0, c_old[g]} + {1'b0, prod_ext[g]};
      if (signed_q)
        lane_sat[g] = (c_old[g][ACC_W-1] == prod_ext[g][ACC_W-1]) &&
                      (sum[g][ACC_W-1] != c_old[g][ACC_W-1]);
      else
        lane_sat[g] = sum[g][ACC_W];
      if (!lane_sat[g])
        acc_new[g] = sum[g][ACC_W-1:0];
      else if (signed_q)
        acc_new[g] = prod_ext[g][ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
      else
        acc_new[g] = '1;
`else
      acc_new[g] = c_old[g] + prod_ext[g];
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < MAX_DIM; r++)
        for (int c = 0; c < MAX_DIM; c++)
          c_mem[r][c] <= '0;
      i_idx <= '0;
      j_idx <= '0;
      p_idx <= '0;
      err_q <= 1'b0;
`ifdef MATMUL_SAT_EN
      ovf_q <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            err_q <= dims_bad;
`ifdef MATMUL_SAT_EN
            ovf_q <= 1'b0;
`endif
          end
        end
        CLEAR: begin
          for (int r = 0; r < MAX_DIM; r++)
            for (int c = 0; c < MAX_DIM; c++)
              c_mem[r][c] <= '0;
          i_idx <= '0;
          j_idx <= '0;
          p_idx <= '0;
        end
        MAC: begin
          for (int g = 0; g < LANES; g++) begin
            if (lane_en[g]) begin
              c_mem[row_sel[g]][j_idx] <= acc_new[g];
`ifdef MATMUL_SAT_EN
              if (lane_sat[g]) ovf_q <= 1'b1;
`endif
            end
          end
          if (!p_last) begin
            p_idx <= p_idx + SEL_W'(1);
          end else begin
            p_idx <= '0;
            if (!j_last) begin
              j_idx <= j_idx + SEL_W'(1);
            end else begin
              j_idx <= '0;
              i_idx <= i_step;
            end
          end
        end
        default: ;
      endcase
    end
  end

  for (genvar r = 0; r < MAX_DIM; r++) begin : g_row
    for (genvar c = 0; c < MAX_DIM; c++) begin : g_col
      assign c_o[(r*MAX_DIM+c)*ACC_W +: ACC_W] = c_mem[r][c];
    end
  end

  assign err = err_q;
`ifdef MATMUL_SAT_EN
  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: doc/matmul_engine_param.md
Name: matmul_engine_param

Overview:
- Parametrised successor of the fixed-layout matrix multiplier: computes C = A x B with runtime dimensions M x K times K x N, each up to MAX_DIM.
- Rows of C are computed LANES at a time.
- Adds start/busy/done handshake, operand latching, dimension checking, and signed/unsigned mode.
- Sits beside the other compute blocks on the packed-bus memory interface; software loads operands, pulses start, then reads c_o.

Parameters:
- DATA_W, 16, operand element width.
- MAX_DIM, 4, maximum of M, K and N. All packed buses use row stride MAX_DIM.
- LANES, 2, rows of C updated per MAC cycle (1..MAX_DIM).
- ACC_W, 2*DATA_W+$clog2(MAX_DIM), width of each C element.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- signed_mode  in  1  1 = two's-complement operands, 0 = unsigned; latched at start.
- m_i / k_i / n_i  in  $clog2(MAX_DIM+1) each  dimensions M, K, N; latched at start.
- a_i  in  DATA_W*MAX_DIM*MAX_DIM  A[r][c] at element index r*MAX_DIM+c.
- b_i  in  DATA_W*MAX_DIM*MAX_DIM  B[r][c], same layout as a_i.
- c_o  out  ACC_W*MAX_DIM*MAX_DIM  C[r][c], same layout; registered.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle completion pulse.
- err  out  1  dimension error of the last request; held until next accepted start.
- ovf  out  1  sticky accumulation overflow (see Optional Feature).

Behaviour:
- Reset (any state, including mid-operation): state=IDLE; c_o, busy, done, err, ovf = 0; indices cleared.
- Cycle 0 = edge at which start=1 is seen in IDLE.
  - Latch a_i, b_i, dims and mode. Inputs may change afterwards without effect.
  - Clear err and ovf.
- Dimension check at cycle 0: any of M, K, N equal to 0 or above MAX_DIM gives an error.
  - Go directly to DONE with err=1. c_o is left unchanged.
  - done pulses in cycle 1.
- States:
  - IDLE: wait for start. A valid start goes to CLEAR.
  - CLEAR (1 cycle): all c_o elements set to 0; i=j=p=0; busy=1. Go to MAC.
  - MAC: for each lane g in 0..LANES-1 with i+g < M, C[i+g][j] += ext(A[i+g][p]) * ext(B[p][j]). Lanes with i+g >= M are masked and write nothing.
  - MAC index stepping:
    - If p < K-1, p++.
    - Else p=0 and j++.
    - When j reaches N: j=0 and i += LANES.
    - When i >= M: go to DONE.
  - DONE (1 cycle): done=1, busy=0. Go to IDLE.
- Latency: T = ceil(M/LANES)*N*K MAC cycles. done is high in cycle T+2 and busy is high in cycles 1..T+1.
- start while busy is ignored.
- start in the DONE cycle is ignored; it is accepted only in the following IDLE cycle.
- Arithmetic:
  - ext() sign-extends when signed_mode=1 and zero-extends otherwise.
  - The product is formed at 2*DATA_W, extended to ACC_W, then added.
  - Elements of C outside M x N read 0 after a valid run.

Optional Feature:
- Macro: MATMUL_SAT_EN.
- Defined:
  - Each accumulation saturates to the ACC_W range: signed min/max in signed mode, 0 / all-ones in unsigned mode.
  - ovf goes high, sticky, on any saturating add.
- Undefined:
  - Accumulation wraps modulo 2^ACC_W.
  - ovf is tied to 0.

Test Plan:
1. M=K=N=2, unsigned, A=[1 2;3 4], B=[5 6;7 8] -> c_o C=[19 22;43 50], done pulse in cycle 6, busy in cycles 1..5, err=0.
2. M=3, K=1, N=1, A col=[1,2,3], B=[4] -> C col=[4,8,12], C[3][0]=0 (masked lane), done in cycle 4.
3. Signed: M=K=N=1, A=0xFFFF, B=3 -> C[0][0]=-3, i.e. ACC_W all-ones except 0b...01. Unsigned repeat -> 0x2FFFD.
4. k_i=0 -> err=1, done in cycle 1, c_o unchanged from prior run. Next valid start clears err.
5. Reset asserted in a MAC cycle of test 1 -> next cycle all outputs 0 and state IDLE. start pulsed during busy of a fresh run is ignored, and done occurs exactly once.
6. ACC_W=32, unsigned, M=N=1, K=4, all elements 0xFFFF:
   - without MATMUL_SAT_EN: C=0xFFF80004, ovf=0.
   - with MATMUL_SAT_EN: C=0xFFFFFFFF, ovf=1.
